// File: rtl/uart_rx_unit_if.sv
// Byte-side interface of the UART receiver: framed data plus status strobes.
// The receiver drives it as master; echo/command units consume it as slave.
interface uart_rx_unit_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_err;
  logic       rx_idle;

  modport master (output rx_data, rx_ready, frame_err, rx_idle);
  modport slave  (input  rx_data, rx_ready, frame_err, rx_idle);
endinterface

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start detection, stop-bit framing check, break wait after a framing error.
module uart_rx_unit #(
  parameter int clk_freq = 12_000_000,
  parameter int baud     = 115200
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           rx,
  uart_rx_unit_if.master rxo
);
  localparam int BIT_CNT  = clk_freq / baud;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 2;
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CNT - 1);

  if (BIT_CNT < 4) begin : g_bad_cfg
    $error("uart_rx_unit: clk_freq/baud must be at least 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [7:0]    data_q, data_nx;
  logic          rdy_q, rdy_nx;
  logic          ferr_q, ferr_nx;
  logic          sync1, rx_s, rx_s_d;

  // Synchronizer resets to the idle-line level so reset release alone is not a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= rx;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      data_q  <= data_nx;
      rdy_q   <= rdy_nx;
      ferr_q  <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = data_q;
    rdy_nx     = 1'b0;
    ferr_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_s_d && !rx_s) begin
          state_nx = S_START;
          cnt_nx   = '0;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a high here was only a glitch.
        if (cnt == HALF_M1) begin
          cnt_nx = '0;
          if (!rx_s) begin
            state_nx   = S_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_M1) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_nx = S_STOP;
          else                 bit_idx_nx = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_M1) begin
          cnt_nx = '0;
          if (rx_s) begin
            data_nx  = shreg;
            rdy_nx   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must go high before a new start edge can be seen.
        if (rx_s) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign rxo.rx_data   = data_q;
  assign rxo.rx_ready  = rdy_q;
  assign rxo.frame_err = ferr_q;
  assign rxo.rx_idle   = (state == S_IDLE);
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at default 104 clk/bit: framing, latency,
// glitch rejection, back-to-back frames, break handling, reset abort, baud skew.
module tb_uart_rx_unit;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;

  uart_rx_unit_if bus();

  uart_rx_unit #(.clk_freq(12_000_000), .baud(115200)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .rxo(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  // Output monitor, sampled on the falling edge
  int         n_rdy = 0, n_ferr = 0, n_overlap = 0, n_wide = 0;
  int         last_rdy_cyc = 0;
  logic [7:0] rdq[$];
  logic       idle_after_rdy = 1'b0;
  logic       prev_rdy = 1'b0, prev_ferr = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_rdy) idle_after_rdy = bus.rx_idle;
      if (bus.rx_ready) begin
        n_rdy++;
        last_rdy_cyc = cyc;
        rdq.push_back(bus.rx_data);
      end
      if (bus.frame_err) n_ferr++;
      if (bus.rx_ready && bus.frame_err) n_overlap++;
      if ((bus.rx_ready && prev_rdy) || (bus.frame_err && prev_ferr)) n_wide++;
      prev_rdy  = bus.rx_ready;
      prev_ferr = bus.frame_err;
    end
  end

  int edge_cyc;

  // Called at a falling clock edge; drives one 8N1 frame, bl cycles per bit.
  task automatic send_byte(input logic [7:0] b, input int bl, input logic stopb);
    rx = 1'b0;
    edge_cyc = cyc;
    repeat (bl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bl) @(negedge clk);
    end
    rx = stopb;
    repeat (bl) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic gap(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.rx_data !== 8'h00) begin errs++; $display("FAIL reset_rx_data got %h want 00", bus.rx_data); end
    checks++; if (bus.rx_ready !== 1'b0) begin errs++; $display("FAIL reset_rx_ready got %b want 0", bus.rx_ready); end
    checks++; if (bus.frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
    checks++; if (bus.rx_idle !== 1'b1) begin errs++; $display("FAIL reset_rx_idle got %b want 1", bus.rx_idle); end
    resetn = 1'b1;
    gap(20);
  endtask

  task automatic test_basic();
    int r0, f0;
    r0 = n_rdy; f0 = n_ferr; rdq.delete();
    send_byte(8'h41, 104, 1'b1);
    gap(208);
    checks++; if (n_rdy - r0 !== 1) begin errs++; $display("FAIL basic_pulses got %0d want 1", n_rdy - r0); end
    checks++; if (rdq.size() < 1 || rdq[0] !== 8'h41) begin errs++; $display("FAIL basic_data got %h want 41", (rdq.size() > 0) ? rdq[0] : 8'hxx); end
    checks++; if (n_ferr - f0 !== 0) begin errs++; $display("FAIL basic_ferr got %0d want 0", n_ferr - f0); end
    // 2 sync cycles + half bit + 9 bits + registered output
    checks++; if (last_rdy_cyc - edge_cyc !== 2 + 52 + 9*104 + 1) begin errs++; $display("FAIL basic_latency got %0d want %0d", last_rdy_cyc - edge_cyc, 2 + 52 + 9*104 + 1); end
    checks++; if (idle_after_rdy !== 1'b1) begin errs++; $display("FAIL basic_idle_after got %b want 1", idle_after_rdy); end
    checks++; if (bus.rx_data !== 8'h41) begin errs++; $display("FAIL basic_hold got %h want 41", bus.rx_data); end
  endtask

  task automatic test_glitch();
    int r0, f0, k;
    r0 = n_rdy; f0 = n_ferr;
    rx = 1'b0;
    edge_cyc = cyc;
    repeat (5) @(negedge clk);
    checks++; if (bus.rx_idle !== 1'b0) begin errs++; $display("FAIL glitch_idle_drop got %b want 0", bus.rx_idle); end
    repeat (15) @(negedge clk);
    rx = 1'b1;
    k = 0;
    while (bus.rx_idle !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    checks++; if (bus.rx_idle !== 1'b1 || cyc - edge_cyc > 3 + 53) begin errs++; $display("FAIL glitch_idle_return got idle=%b after %0d cycles want 1 within %0d", bus.rx_idle, cyc - edge_cyc, 3 + 53); end
    gap(300);
    checks++; if (n_rdy - r0 !== 0 || n_ferr - f0 !== 0) begin errs++; $display("FAIL glitch_pulses got rdy=%0d ferr=%0d want 0 0", n_rdy - r0, n_ferr - f0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    int r0;
    exp[0] = 8'h0D; exp[1] = 8'h08; exp[2] = 8'h7F;
    r0 = n_rdy; rdq.delete();
    for (int i = 0; i < 3; i++) send_byte(exp[i], 104, 1'b1);
    gap(208);
    checks++; if (n_rdy - r0 !== 3) begin errs++; $display("FAIL b2b_pulses got %0d want 3", n_rdy - r0); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rdq.size() <= i || rdq[i] !== exp[i]) begin errs++; $display("FAIL b2b_data%0d got %h want %h", i, (rdq.size() > i) ? rdq[i] : 8'hxx, exp[i]); end
    end
  endtask

  task automatic test_frame_err();
    int r0, f0;
    r0 = n_rdy; f0 = n_ferr; rdq.delete();
    send_byte(8'h55, 104, 1'b0);
    rx = 1'b0;
    repeat (3*104) @(negedge clk);
    checks++; if (n_ferr - f0 !== 1) begin errs++; $display("FAIL ferr_pulses got %0d want 1", n_ferr - f0); end
    checks++; if (n_rdy - r0 !== 0) begin errs++; $display("FAIL ferr_no_ready got %0d want 0", n_rdy - r0); end
    checks++; if (bus.rx_data !== 8'h7F) begin errs++; $display("FAIL ferr_data_held got %h want 7f", bus.rx_data); end
    checks++; if (bus.rx_idle !== 1'b0) begin errs++; $display("FAIL ferr_break_wait got idle=%b want 0", bus.rx_idle); end
    gap(208);
    checks++; if (bus.rx_idle !== 1'b1 || n_rdy - r0 !== 0) begin errs++; $display("FAIL ferr_recover got idle=%b rdy=%0d want 1 0", bus.rx_idle, n_rdy - r0); end
    send_byte(8'hA5, 104, 1'b1);
    gap(208);
    checks++; if (n_rdy - r0 !== 1 || rdq.size() < 1 || rdq[0] !== 8'hA5) begin errs++; $display("FAIL ferr_next_byte got rdy=%0d data=%h want 1 a5", n_rdy - r0, (rdq.size() > 0) ? rdq[0] : 8'hxx); end
  endtask

  task automatic test_reset_abort();
    int r0, f0;
    r0 = n_rdy; f0 = n_ferr; rdq.delete();
    // 0xFF: start bit, then bits 0..3 and half of bit 4 all high
    rx = 1'b0;
    repeat (104) @(negedge clk);
    rx = 1'b1;
    repeat (4*104 + 52) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++; if (bus.rx_data !== 8'h00 || bus.rx_ready !== 1'b0 || bus.frame_err !== 1'b0 || bus.rx_idle !== 1'b1)
      begin errs++; $display("FAIL abort_reset_vals got data=%h rdy=%b ferr=%b idle=%b want 00 0 0 1", bus.rx_data, bus.rx_ready, bus.frame_err, bus.rx_idle); end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    gap(700);
    checks++; if (n_rdy - r0 !== 0 || n_ferr - f0 !== 0) begin errs++; $display("FAIL abort_no_pulse got rdy=%0d ferr=%0d want 0 0", n_rdy - r0, n_ferr - f0); end
    send_byte(8'h12, 104, 1'b1);
    gap(208);
    checks++; if (n_rdy - r0 !== 1 || rdq.size() < 1 || rdq[0] !== 8'h12) begin errs++; $display("FAIL abort_next_byte got rdy=%0d data=%h want 1 12", n_rdy - r0, (rdq.size() > 0) ? rdq[0] : 8'hxx); end
  endtask

  task automatic test_baud_skew();
    int bl [2];
    int r0, f0;
    bl[0] = 99; bl[1] = 109;
    for (int i = 0; i < 2; i++) begin
      r0 = n_rdy; f0 = n_ferr; rdq.delete();
      send_byte(8'h3C, bl[i], 1'b1);
      gap(2*bl[i]);
      checks++; if (n_rdy - r0 !== 1 || rdq.size() < 1 || rdq[0] !== 8'h3C || n_ferr - f0 !== 0)
        begin errs++; $display("FAIL skew_%0d got rdy=%0d data=%h ferr=%0d want 1 3c 0", bl[i], n_rdy - r0, (rdq.size() > 0) ? rdq[0] : 8'hxx, n_ferr - f0); end
    end
  endtask

  task automatic test_pulse_shape();
    checks++; if (n_overlap !== 0) begin errs++; $display("FAIL pulse_overlap got %0d want 0", n_overlap); end
    checks++; if (n_wide !== 0) begin errs++; $display("FAIL pulse_width got %0d multi-cycle pulses want 0", n_wide); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_frame_err();
    test_reset_abort();
    test_baud_skew();
    test_pulse_shape();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- Asynchronous UART receiver, 8N1, LSB first. Converts the serial RX pin into byte strobes.
- Sits directly upstream of the echo/command units and drives their rx_data/rx_ready inputs.
- Single clock domain, mid-bit sampling, start-bit glitch rejection, stop-bit framing check.

Parameters:
- clk_freq, 12_000_000, system clock frequency in Hz.
- baud, 115200, line rate in bit/s.
- Derived localparam BIT_CNT = clk_freq / baud (integer truncation; 104 at defaults).
- Derived localparam HALF_CNT = BIT_CNT / 2 (52 at defaults).
- BIT_CNT < 4 is unsupported; simulation-only $error on elaboration.

Ports:
- clk  input  1  system clock, all logic on posedge.
- resetn  input  1  asynchronous active-low reset.
- rx  input  1  raw serial line, asynchronous to clk, idle high.
- rx_data  output  8  last correctly framed byte; held until the next good byte.
- rx_ready  output  1  one-cycle pulse, rx_data valid in the same cycle.
- frame_err  output  1  one-cycle pulse, stop bit sampled low.
- rx_idle  output  1  high when state == S_IDLE.

Behaviour:
- Interface (decided): one clock, clk; reset resetn is asynchronous, active-low.
- Reset values: rx_data=0, rx_ready=0, frame_err=0, rx_idle=1. Synchronizer flops=1, state=S_IDLE, counters=0, shift register=0.
- Synchronizer: rx passes through 2 flops to give rx_s. A third flop holds rx_s_d (previous rx_s). All decisions use rx_s only.
- Counters:
  - cnt is wide enough for BIT_CNT-1. It clears on every state change and on every bit-sample event, otherwise increments.
  - bit_idx is 3 bits.
- States:
  - S_IDLE: if rx_s_d==1 and rx_s==0 (falling edge, cycle t0) -> S_START, cnt=0.
  - S_START: at cnt==HALF_CNT-1 (cycle t0+HALF_CNT):
    - rx_s==0 -> S_DATA, bit_idx=0.
    - rx_s==1 -> S_IDLE (glitch). No output pulse.
  - S_DATA: at cnt==BIT_CNT-1, shift rx_s into the shift register MSB side (right shift, LSB first on the line).
    - Bit i is sampled at cycle t0+HALF_CNT+(i+1)*BIT_CNT.
    - After bit_idx==7 -> S_STOP, else bit_idx+1.
  - S_STOP: sampled at cnt==BIT_CNT-1, i.e. cycle ts = t0+HALF_CNT+9*BIT_CNT.
    - rx_s==1: rx_data <= shift register, rx_ready=1 during cycle ts+1 only -> S_IDLE.
    - rx_s==0: frame_err=1 during cycle ts+1 only, rx_data unchanged -> S_BREAK.
  - S_BREAK: wait until rx_s==1 -> S_IDLE. A low line cannot retrigger a start.
- Pulse timing: rx_ready and frame_err are registered, never high together, and each is high for exactly 1 cycle.
- Back-to-back frames: a start edge arriving right after the stop sample is detected normally. S_IDLE is re-entered at ts+1, and the next falling edge cannot occur earlier than half a bit later.
- Reset mid-frame: immediate return to reset values. Partial byte discarded, no pulse. After release, resynchronise on the next falling edge. If the line is low at release, no start fires until a high-to-low edge is seen.
- No buffering: the downstream unit must capture on rx_ready. Overrun is the consumer's concern.

Test Plan:
1. Defaults (BIT_CNT=104). Drive 8N1 frame 0x41 at exactly 104 clk/bit.
   -> one rx_ready pulse, rx_data=0x41, frame_err never high, rx_idle high again the cycle after the pulse.
   -> Pulse arrives at edge_seen + 52 + 9*104 + 1 cycles.
2. Glitch: rx low for 20 cycles, then high.
   -> no rx_ready, no frame_err.
   -> rx_idle drops at the edge, returns within 53 cycles.
3. Back-to-back 0x0D, 0x08, 0x7F, no idle gap.
   -> exactly three rx_ready pulses carrying 0x0D, 0x08, 0x7F in order.
4. Frame 0x55 with stop bit driven 0, then line held low 3 bit times, then high, then a good 0xA5.
   -> one frame_err pulse, rx_data stays at its prior value, no spurious start while low.
   -> then rx_ready with 0xA5.
5. Assert resetn low during data bit 4 of 0xFF for 3 cycles, release, send 0x12.
   -> outputs at reset values during reset, no pulse for the aborted byte.
   -> rx_ready with 0x12 afterwards.
6. Baud tolerance: 0x3C sent at 99 and at 109 clk/bit (about ±5%).
   -> both received as 0x3C without frame_err.
